// File: rtl/vram_dual_fill.sv
// vram_dual_fill
//   Single-clock character/attribute RAM for a text-mode video path.
//   The CPU writes through one port, the video scan reads through the other, and
//   a fill engine clears the whole buffer to one word after reset or on request.
//
//   Ports
//     clk, rst_n             clock (rising edge) and asynchronous active-low reset
//     wr_en/wr_addr/wr_data  CPU write request; accepted only while wr_ready=1
//     wr_ready               low while the fill engine owns the write port
//     rd_en/rd_addr          read request; rd_data/rd_valid follow RD_LAT edges later
//     rd_data/rd_valid       read result and qualifier (data holds while valid=0)
//     fill_start/fill_value  request a fill with fill_value (looked at only when idle)
//     fill_busy              fill engine running
//     fill_done              one-cycle pulse after the last fill write
module vram_dual_fill #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 2560,
  parameter int FILL_VAL  = 32,
  parameter int AUTO_FILL = 1,
  parameter int RD_LAT    = 1,
  parameter int BYPASS    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              AW1        = ADDR_W + 1;
  localparam logic [AW1-1:0]  DEPTH_X    = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_VAL);
  localparam logic            AUTO_BIT   = (AUTO_FILL != 0);
  localparam logic            BYPASS_BIT = (BYPASS != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fval_q, fval_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrdy_q, wrdy_d;
  // Set by reset when AUTO_FILL is on; the first edge after release consumes it.
  logic              auto_q, auto_d;

  logic              fill_we_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              rd_hit_s;
  logic [DATA_W-1:0] rd_word_s;

  logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
  logic              rd1_valid_q, rd1_valid_d;

  // Fill FSM: next state, counter, latched fill word and status flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fval_d    = fval_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrdy_d    = wrdy_q;
    auto_d    = 1'b0;
    fill_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (auto_q || fill_start) begin
          // The post-reset auto fill behaves like a fill_start carrying FILL_VAL.
          state_d = ST_FILL;
          cnt_d   = {ADDR_W{1'b0}};
          fval_d  = auto_q ? FILL_WORD : fill_value;
          busy_d  = 1'b1;
          wrdy_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        fill_we_s = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          // Last word: counter parks here instead of wrapping.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          wrdy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        wrdy_d  = 1'b1;
      end
    endcase
  end

  // Fill FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      fval_q  <= {DATA_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrdy_q  <= 1'b1;
      auto_q  <= AUTO_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fval_q  <= fval_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrdy_q  <= wrdy_d;
      auto_q  <= auto_d;
    end
  end

  // Write-port arbitration: the fill engine owns the port while it runs
  always_comb begin
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_X);
    if (fill_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q[IDX_W-1:0];
      mem_wdata_s = fval_q;
    end else begin
      mem_we_s    = wr_en && wrdy_q && wr_in_range_s;
      mem_waddr_s = wr_addr[IDX_W-1:0];
      mem_wdata_s = wr_data;
    end
  end

  // Storage array (contents deliberately survive reset)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read word selection: out-of-range reads return zero, collisions per BYPASS
  always_comb begin
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_X);
    rd_hit_s      = BYPASS_BIT && mem_we_s && (mem_waddr_s == rd_addr[IDX_W-1:0]);
    if (!rd_in_range_s) begin
      rd_word_s = {DATA_W{1'b0}};
    end else if (rd_hit_s) begin
      rd_word_s = mem_wdata_s;
    end else begin
      rd_word_s = mem[rd_addr[IDX_W-1:0]];
    end
  end

  // First read stage: capture on rd_en, otherwise hold the last word
  always_comb begin
    rd1_valid_d = rd_en;
    if (rd_en) begin
      rd1_data_d = rd_word_s;
    end else begin
      rd1_data_d = rd1_data_q;
    end
  end

  // First read stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data_q  <= {DATA_W{1'b0}};
      rd1_valid_q <= 1'b0;
    end else begin
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd2_data_q, rd2_data_d;
      logic              rd2_valid_q, rd2_valid_d;

      // Output stage: forward only qualified words so rd_data holds between reads
      always_comb begin
        rd2_valid_d = rd1_valid_q;
        if (rd1_valid_q) begin
          rd2_data_d = rd1_data_q;
        end else begin
          rd2_data_d = rd2_data_q;
        end
      end

      // Output stage registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_data_q  <= {DATA_W{1'b0}};
          rd2_valid_q <= 1'b0;
        end else begin
          rd2_data_q  <= rd2_data_d;
          rd2_valid_q <= rd2_valid_d;
        end
      end

      assign rd_data  = rd2_data_q;
      assign rd_valid = rd2_valid_q;
    end else begin : g_lat1
      assign rd_data  = rd1_data_q;
      assign rd_valid = rd1_valid_q;
    end
  endgenerate

  assign wr_ready  = wrdy_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

endmodule

// File: tb/tb_vram_dual_fill.sv
`timescale 1ns/1ps
// Bench for vram_dual_fill. Instance A uses the default parameters (auto fill,
// one-cycle read, read-first collisions). Instance B is a small 64-word buffer
// with no auto fill, two-cycle read and write-through collisions.
module tb_vram_dual_fill;

  localparam int A_DEPTH = 2560;
  localparam int B_DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n, rst_n_b;

  logic        a_wr_en, a_wr_ready, a_rd_en, a_rd_valid, a_fill_start, a_fill_busy, a_fill_done;
  logic [12:0] a_wr_addr, a_rd_addr;
  logic [7:0]  a_wr_data, a_rd_data, a_fill_value;

  logic        b_wr_en, b_wr_ready, b_rd_en, b_rd_valid, b_fill_start, b_fill_busy, b_fill_done;
  logic [7:0]  b_wr_addr, b_rd_addr;
  logic [7:0]  b_wr_data, b_rd_data, b_fill_value;

  typedef struct {
    logic [7:0] data;
    int         due;
    int         addr;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] model_a [A_DEPTH];
  logic [7:0] model_b [B_DEPTH];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vram_dual_fill dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .fill_start(a_fill_start), .fill_value(a_fill_value),
    .fill_busy(a_fill_busy), .fill_done(a_fill_done)
  );

  vram_dual_fill #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(B_DEPTH), .FILL_VAL(32),
    .AUTO_FILL(0), .RD_LAT(2), .BYPASS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .fill_start(b_fill_start), .fill_value(b_fill_value),
    .fill_busy(b_fill_busy), .fill_done(b_fill_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the next falling edge and retire any read results against the queues.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (a_rd_valid === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL sb_a_spurious: rd_valid=1 at cycle %0d, required 0 (no read outstanding)", cyc);
      end else begin
        e = qa.pop_front();
        if (a_rd_data !== e.data || cyc != e.due) begin
          failures++;
          $display("FAIL sb_a_read addr=%0h: got data=%0h at cycle %0d, required data=%0h at cycle %0d",
                   e.addr, a_rd_data, cyc, e.data, e.due);
        end
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      checks++;
      failures++;
      e = qa.pop_front();
      $display("FAIL sb_a_missing addr=%0h: rd_valid=%b at cycle %0d, required 1", e.addr, a_rd_valid, cyc);
    end
    if (b_rd_valid === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL sb_b_spurious: rd_valid=1 at cycle %0d, required 0 (no read outstanding)", cyc);
      end else begin
        e = qb.pop_front();
        if (b_rd_data !== e.data || cyc != e.due) begin
          failures++;
          $display("FAIL sb_b_read addr=%0h: got data=%0h at cycle %0d, required data=%0h at cycle %0d",
                   e.addr, b_rd_data, cyc, e.data, e.due);
        end
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      checks++;
      failures++;
      e = qb.pop_front();
      $display("FAIL sb_b_missing addr=%0h: rd_valid=%b at cycle %0d, required 1", e.addr, b_rd_valid, cyc);
    end
  endtask

  task automatic wr_a(input int addr, input logic [7:0] data);
    a_wr_en = 1'b1; a_wr_addr = 13'(addr); a_wr_data = data;
    cycle();
    a_wr_en = 1'b0;
    if (addr < A_DEPTH) model_a[addr] = data;
  endtask

  task automatic wr_b(input int addr, input logic [7:0] data);
    b_wr_en = 1'b1; b_wr_addr = 8'(addr); b_wr_data = data;
    cycle();
    b_wr_en = 1'b0;
    if (addr < B_DEPTH) model_b[addr] = data;
  endtask

  task automatic rd_a(input int addr);
    exp_t e;
    a_rd_en = 1'b1; a_rd_addr = 13'(addr);
    e.addr = addr; e.due = cyc + 1;
    e.data = (addr < A_DEPTH) ? model_a[addr] : 8'h00;
    qa.push_back(e);
    cycle();
    a_rd_en = 1'b0;
  endtask

  task automatic rd_b(input int addr);
    exp_t e;
    b_rd_en = 1'b1; b_rd_addr = 8'(addr);
    e.addr = addr; e.due = cyc + 2;
    e.data = (addr < B_DEPTH) ? model_b[addr] : 8'h00;
    qb.push_back(e);
    cycle();
    b_rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_b = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = 13'h0; a_wr_data = 8'h00; a_rd_en = 1'b0; a_rd_addr = 13'h0;
    a_fill_start = 1'b0; a_fill_value = 8'h00;
    b_wr_en = 1'b0; b_wr_addr = 8'h0; b_wr_data = 8'h00; b_rd_en = 1'b0; b_rd_addr = 8'h0;
    b_fill_start = 1'b0; b_fill_value = 8'h00;
    repeat (3) cycle();
    checks++;
    if ({a_rd_valid, a_fill_busy, a_fill_done, a_wr_ready} !== 4'b0001 || a_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_a: got valid/busy/done/ready=%b%b%b%b data=%0h, required 0001 data=0",
               a_rd_valid, a_fill_busy, a_fill_done, a_wr_ready, a_rd_data);
    end
    checks++;
    if ({b_rd_valid, b_fill_busy, b_fill_done, b_wr_ready} !== 4'b0001 || b_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_b: got valid/busy/done/ready=%b%b%b%b data=%0h, required 0001 data=0",
               b_rd_valid, b_fill_busy, b_fill_done, b_wr_ready, b_rd_data);
    end
  endtask

  task automatic test_auto_fill();
    int busy_cnt = 0, done_cnt = 0, rdy_bad = 0, b_seen = 0;
    logic done_at_end = 1'b0;
    rst_n = 1'b1; rst_n_b = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (a_fill_busy === 1'b1) busy_cnt++;
      if (a_fill_done === 1'b1) done_cnt++;
      if (a_wr_ready !== ~a_fill_busy) rdy_bad++;
      if (b_fill_busy !== 1'b0 || b_fill_done !== 1'b0) b_seen++;
      if (busy_cnt > 0 && a_fill_busy === 1'b0) begin
        done_at_end = a_fill_done;
        break;
      end
    end
    cycle();
    if (a_fill_done === 1'b1) done_cnt++;
    checks++;
    if (busy_cnt != A_DEPTH) begin
      failures++;
      $display("FAIL auto_fill_busy_len: got %0d cycles, required %0d", busy_cnt, A_DEPTH);
    end
    checks++;
    if (done_cnt != 1 || done_at_end !== 1'b1) begin
      failures++;
      $display("FAIL auto_fill_done: got %0d pulses (at end=%b), required 1 (at end=1)", done_cnt, done_at_end);
    end
    checks++;
    if (rdy_bad != 0) begin
      failures++;
      $display("FAIL auto_fill_wr_ready: got %0d cycles with wr_ready==fill_busy, required 0", rdy_bad);
    end
    checks++;
    if (b_seen != 0) begin
      failures++;
      $display("FAIL b_no_auto_fill: got %0d busy/done cycles, required 0", b_seen);
    end
    for (int k = 0; k < A_DEPTH; k++) model_a[k] = 8'd32;
  endtask

  task automatic test_back_to_back_a();
    for (int k = 0; k < A_DEPTH; k++) rd_a(k);
    drain();
  endtask

  task automatic test_write_read_a();
    int         addrs [6];
    logic [7:0] pats  [6];
    addrs = '{0, 1, 2559, 'h7FF, 'h400, 'h123};
    pats  = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80};
    wr_a(5, 8'h41);
    rd_a(5);
    drain();
    for (int i = 0; i < 6; i++) wr_a(addrs[i], pats[i]);
    for (int i = 0; i < 6; i++) rd_a(addrs[i]);
    drain();
    cycle();
    checks++;
    if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h80) begin
      failures++;
      $display("FAIL hold_a: got valid=%b data=%0h, required valid=0 data=80", a_rd_valid, a_rd_data);
    end
  endtask

  task automatic test_collision_a();
    exp_t e;
    wr_a('h10, 8'h20);
    a_wr_en = 1'b1; a_wr_addr = 13'h010; a_wr_data = 8'h55;
    a_rd_en = 1'b1; a_rd_addr = 13'h010;
    e.addr = 'h10; e.data = 8'h20; e.due = cyc + 1;
    qa.push_back(e);
    cycle();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    model_a['h10] = 8'h55;
    rd_a('h10);
    drain();
  endtask

  task automatic test_fill_request_a();
    int   busy_cnt, done_cnt = 0;
    exp_t e;
    a_fill_value = 8'h00; a_fill_start = 1'b1;
    cycle();
    a_fill_start = 1'b0;
    busy_cnt = (a_fill_busy === 1'b1) ? 1 : 0;
    checks++;
    if (a_fill_busy !== 1'b1 || a_wr_ready !== 1'b0 || a_fill_done !== 1'b0) begin
      failures++;
      $display("FAIL fill_req_enter: got busy/ready/done=%b%b%b, required 100", a_fill_busy, a_wr_ready, a_fill_done);
    end
    for (int i = 0; i < 4000; i++) begin
      a_rd_en = 1'b0; a_wr_en = 1'b0; a_fill_start = 1'b0;
      if (i == 10 || i == 11) begin
        a_rd_en = 1'b1;
        a_rd_addr = (i == 10) ? 13'd5 : 13'd2000;
        e.addr = int'(a_rd_addr); e.due = cyc + 1;
        e.data = (i == 10) ? 8'h00 : model_a[2000];
        qa.push_back(e);
      end
      if (i == 500) begin
        a_wr_en = 1'b1; a_wr_addr = 13'h100; a_wr_data = 8'hAA;
        a_fill_start = 1'b1; a_fill_value = 8'h77;
        checks++;
        if (a_wr_ready !== 1'b0) begin
          failures++;
          $display("FAIL fill_req_wr_ready: got %b, required 0", a_wr_ready);
        end
      end
      cycle();
      if (a_fill_busy === 1'b1) busy_cnt++;
      if (a_fill_done === 1'b1) done_cnt++;
      if (a_fill_busy !== 1'b1) break;
    end
    a_rd_en = 1'b0; a_wr_en = 1'b0; a_fill_start = 1'b0;
    checks++;
    if (busy_cnt != A_DEPTH || done_cnt != 1) begin
      failures++;
      $display("FAIL fill_req_len: got busy=%0d done=%0d, required busy=%0d done=1", busy_cnt, done_cnt, A_DEPTH);
    end
    for (int k = 0; k < A_DEPTH; k++) model_a[k] = 8'h00;
    rd_a('h100);
    rd_a(2559);
    rd_a(0);
    drain();
  endtask

  task automatic test_out_of_range_a();
    checks++;
    if (a_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_a_ready: got wr_ready=%b, required 1", a_wr_ready);
    end
    wr_a('hA00, 8'h99);
    wr_a('h1005, 8'h99);
    rd_a('hA00);
    rd_a('h1005);
    rd_a(5);
    rd_a('h9FF);
    drain();
  endtask

  task automatic test_reset_midfill_a();
    int   busy_cnt = 0, done_cnt = 0;
    exp_t e;
    a_fill_value = 8'h11; a_fill_start = 1'b1;
    cycle();
    a_fill_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a_rd_en = 1'b0;
      if (i == 500) begin
        a_rd_en = 1'b1; a_rd_addr = 13'd3;
        e.addr = 3; e.data = 8'h11; e.due = cyc + 1;
        qa.push_back(e);
      end
      cycle();
    end
    a_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rd_valid, a_fill_busy, a_fill_done, a_wr_ready} !== 4'b0001 || a_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL midfill_a_reset: got valid/busy/done/ready=%b%b%b%b data=%0h, required 0001 data=0",
               a_rd_valid, a_fill_busy, a_fill_done, a_wr_ready, a_rd_data);
    end
    qa.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      a_rd_en = 1'b0;
      if (i >= 1 && i <= 4) begin
        a_rd_en = 1'b1;
        case (i)
          1:       begin a_rd_addr = 13'd1500; e.data = 8'h00; end
          2:       begin a_rd_addr = 13'd999;  e.data = 8'h11; end
          3:       begin a_rd_addr = 13'd1000; e.data = 8'h00; end
          default: begin a_rd_addr = 13'd500;  e.data = 8'h11; end
        endcase
        e.addr = int'(a_rd_addr); e.due = cyc + 1;
        qa.push_back(e);
      end
      cycle();
      if (a_fill_busy === 1'b1) busy_cnt++;
      if (a_fill_done === 1'b1) done_cnt++;
      if (busy_cnt > 0 && a_fill_busy !== 1'b1) break;
    end
    a_rd_en = 1'b0;
    checks++;
    if (busy_cnt != A_DEPTH || done_cnt != 1) begin
      failures++;
      $display("FAIL midfill_a_restart: got busy=%0d done=%0d, required busy=%0d done=1", busy_cnt, done_cnt, A_DEPTH);
    end
    for (int k = 0; k < A_DEPTH; k++) model_a[k] = 8'd32;
    rd_a(0);
    rd_a(1000);
    rd_a(2559);
    drain();
  endtask

  task automatic test_fill_b();
    int busy_cnt, done_cnt = 0;
    b_fill_value = 8'h5A; b_fill_start = 1'b1;
    cycle();
    b_fill_start = 1'b0;
    busy_cnt = (b_fill_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (b_fill_busy === 1'b1) busy_cnt++;
      if (b_fill_done === 1'b1) done_cnt++;
      if (b_fill_busy !== 1'b1) break;
    end
    checks++;
    if (busy_cnt != B_DEPTH || done_cnt != 1) begin
      failures++;
      $display("FAIL fill_b_len: got busy=%0d done=%0d, required busy=%0d done=1", busy_cnt, done_cnt, B_DEPTH);
    end
    for (int k = 0; k < B_DEPTH; k++) model_b[k] = 8'h5A;
  endtask

  task automatic test_write_read_b();
    wr_b(5, 8'h41);
    rd_b(5);
    rd_b(63);
    rd_b(5);
    drain();
    cycle();
    checks++;
    if (b_rd_valid !== 1'b0 || b_rd_data !== 8'h41) begin
      failures++;
      $display("FAIL hold_b: got valid=%b data=%0h, required valid=0 data=41", b_rd_valid, b_rd_data);
    end
  endtask

  task automatic test_collision_b();
    exp_t e;
    wr_b('h10, 8'h20);
    b_wr_en = 1'b1; b_wr_addr = 8'h10; b_wr_data = 8'h55;
    b_rd_en = 1'b1; b_rd_addr = 8'h10;
    e.addr = 'h10; e.data = 8'h55; e.due = cyc + 2;
    qb.push_back(e);
    cycle();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    model_b['h10] = 8'h55;
    rd_b('h10);
    drain();
  endtask

  task automatic test_out_of_range_b();
    wr_b(69, 8'h99);
    rd_b(64);
    rd_b(69);
    rd_b(5);
    drain();
  endtask

  task automatic test_reset_midfill_b();
    int idle_bad = 0;
    b_fill_value = 8'h33; b_fill_start = 1'b1;
    cycle();
    b_fill_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (b_fill_done !== 1'b0) idle_bad++;
    end
    rst_n_b = 1'b0;
    #1;
    checks++;
    if ({b_rd_valid, b_fill_busy, b_fill_done, b_wr_ready} !== 4'b0001 || b_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL midfill_b_reset: got valid/busy/done/ready=%b%b%b%b data=%0h, required 0001 data=0",
               b_rd_valid, b_fill_busy, b_fill_done, b_wr_ready, b_rd_data);
    end
    qb.delete();
    cycle();
    cycle();
    rst_n_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (b_fill_busy !== 1'b0 || b_fill_done !== 1'b0 || b_wr_ready !== 1'b1) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      failures++;
      $display("FAIL midfill_b_idle: got %0d cycles with done/busy set or wr_ready low, required 0", idle_bad);
    end
    for (int k = 0; k < 20; k++) model_b[k] = 8'h33;
    for (int k = 0; k < B_DEPTH; k++) rd_b(k);
    drain();
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_auto_fill();
    test_back_to_back_a();
    test_write_read_a();
    test_collision_a();
    test_fill_request_a();
    test_out_of_range_a();
    test_reset_midfill_a();
    test_fill_b();
    test_write_read_b();
    test_collision_b();
    test_out_of_range_b();
    test_reset_midfill_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
